c3_heap_pq: RTL and testbench

Parametrised priority-queue unit for the C3 custom-instruction slot, generalising the fixed 8-bit/25-entry max-heap to configurable key width, depth and min/max ordering. It accepts one command at a time under a ready/valid handshake and supports peek, push, pop and replace (pop-then-push in one operation). Each command returns exactly one tagged response carrying `rd`, so the core can retire it like any other multi-cycle custom instruction. It sits beside the existing C3 pipeline and shares its clock and reset.

---
 rtl/c3_heap_pq_if.sv | 22 ++
 rtl/c3_heap_pq.sv | 157 +++++++++++++++
 tb/tb_c3_heap_pq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/c3_heap_pq_if.sv
// rtl/c3_heap_pq_if.sv - command/response handshake bundle for the C3 priority queue
interface c3_heap_pq_if;
    logic        in_v;
    logic        in_ready;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] in_data;
    logic        out_v;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_err;

    modport master (
        output in_v, op, rd, in_data,
        input  in_ready, out_v, out_rd, out_data, out_err
    );

    modport slave (
        input  in_v, op, rd, in_data,
        output in_ready, out_v, out_rd, out_data, out_err
    );
endinterface

// File: rtl/c3_heap_pq.sv
// rtl/c3_heap_pq.sv - binary-heap priority queue (peek/push/pop/replace), one compare per cycle
module c3_heap_pq #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 25,
    parameter int MIN_HEAP = 0,
    parameter int IDX_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    c3_heap_pq_if.slave      bus,
    output logic [IDX_W-1:0] count,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] OP_PEEK = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_REPL = 2'd3;

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN, RESP} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0] heap [DEPTH];
    logic [IDX_W:0]    idx, parent, lchild, rchild, best, partner;
    logic [1:0]        op_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] key;
    logic [IDX_W-1:0]  last;
    logic              accept, err, swap;

    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (MIN_HEAP != 0) ? (a < b) : (a > b);
    endfunction

    function automatic logic [AW-1:0] ai(input logic [IDX_W:0] i);
        return i[AW-1:0];
    endfunction

    assign key    = bus.in_data[DATA_W-1:0];
    assign last   = count - 1'b1;
    assign parent = (idx - 1'b1) >> 1;
    assign lchild = {idx[IDX_W-1:0], 1'b1};
    assign rchild = lchild + 1'b1;
    assign empty  = (count == '0);
    assign full   = (count == IDX_W'(DEPTH));

    // RESP doubles as an accept slot so back-to-back commands lose no cycle
    assign bus.in_ready = !reset && (state == IDLE || state == RESP);

    // Strict compares: idx beats an equal child, left beats an equal right
    always_comb begin
        best = idx;
        if (lchild < {1'b0, count} && better(heap[ai(lchild)], heap[ai(idx)]))
            best = lchild;
        if (rchild < {1'b0, count} && better(heap[ai(rchild)], heap[ai(best)]))
            best = rchild;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        err     = 1'b0;
        swap    = 1'b0;
        partner = idx;
        case (state)
            IDLE, RESP: begin
                if (state == RESP)
                    state_n = IDLE;
                if (bus.in_v) begin
                    accept = 1'b1;
                    err    = (bus.op == OP_PUSH) ? full : empty;
                    if (err || bus.op == OP_PEEK)
                        state_n = RESP;
                    else if (bus.op == OP_PUSH)
                        state_n = SIFT_UP;
                    else
                        state_n = SIFT_DOWN;
                end
            end
            SIFT_UP: begin
                if (idx != '0 && better(heap[ai(idx)], heap[ai(parent)])) begin
                    swap    = 1'b1;
                    partner = parent;
                end else begin
                    state_n = RESP;
                end
            end
            SIFT_DOWN: begin
                if (best != idx) begin
                    swap    = 1'b1;
                    partner = best;
                end else begin
                    state_n = RESP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            idx          <= '0;
            op_q         <= OP_PEEK;
            rd_q         <= '0;
            res          <= '0;
            bus.out_v    <= 1'b0;
            bus.out_err  <= 1'b0;
            bus.out_data <= '0;
            bus.out_rd   <= '0;
        end else begin
            state     <= state_n;
            bus.out_v <= (state_n == RESP);
            if (accept) begin
                op_q <= bus.op;
                rd_q <= bus.rd;
                res  <= heap[0];
                idx  <= '0;
                if (!err && bus.op == OP_PUSH) begin
                    count <= count + 1'b1;
                    idx   <= {1'b0, count};
                end
                if (!err && bus.op == OP_POP)
                    count <= last;
                if (state_n == RESP) begin
                    bus.out_err  <= err;
                    bus.out_rd   <= bus.rd;
                    bus.out_data <= err ? 32'd0 : 32'(heap[0]);
                end
            end else if (swap) begin
                idx <= partner;
            end else if (state_n == RESP) begin
                bus.out_err  <= 1'b0;
                bus.out_rd   <= rd_q;
                bus.out_data <= (op_q == OP_PUSH) ? 32'(count) : 32'(res);
            end
        end
    end

    // Storage is deliberately unreset; count alone defines which entries are live
    always_ff @(posedge clk) begin
        if (accept && !err) begin
            case (bus.op)
                OP_PUSH: heap[ai({1'b0, count})] <= key;
                OP_POP:  heap[0] <= heap[ai({1'b0, last})];
                OP_REPL: heap[0] <= key;
                default: ;
            endcase
        end else if (swap) begin
            heap[ai(idx)]     <= heap[ai(partner)];
            heap[ai(partner)] <= heap[ai(idx)];
        end
    end
endmodule

// File: tb/tb_c3_heap_pq.sv
// tb/tb_c3_heap_pq.sv - scoreboard bench: DUT0 max/4, DUT1 min/8, DUT2 max/8
module tb_c3_heap_pq;
    localparam logic [1:0] PEEK = 2'd0, PUSH = 2'd1, POP = 2'd2, REPL = 2'd3;

    typedef struct {
        int          dut;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    exp_t sbq[$];

    logic        rst   [3];
    logic        in_v  [3];
    logic [1:0]  op_a  [3];
    logic [4:0]  rd_a  [3];
    logic [31:0] din_a [3];
    logic        rdy_a [3];
    logic        ov_a  [3];
    logic [4:0]  ord_a [3];
    logic [31:0] od_a  [3];
    logic        oe_a  [3];
    logic [31:0] cnt_a [3];
    logic        emp_a [3];
    logic        ful_a [3];

    c3_heap_pq_if b0 ();
    c3_heap_pq_if b1 ();
    c3_heap_pq_if b2 ();

    logic [2:0] c0;
    logic [3:0] c1, c2;
    logic e0, e1, e2, f0, f1, f2;

    c3_heap_pq #(.DATA_W(8), .DEPTH(4), .MIN_HEAP(0)) u0 (
        .clk(clk), .reset(rst[0]), .bus(b0), .count(c0), .empty(e0), .full(f0));
    c3_heap_pq #(.DATA_W(8), .DEPTH(8), .MIN_HEAP(1)) u1 (
        .clk(clk), .reset(rst[1]), .bus(b1), .count(c1), .empty(e1), .full(f1));
    c3_heap_pq #(.DATA_W(8), .DEPTH(8), .MIN_HEAP(0)) u2 (
        .clk(clk), .reset(rst[2]), .bus(b2), .count(c2), .empty(e2), .full(f2));

    assign b0.in_v = in_v[0];  assign b0.op = op_a[0];  assign b0.rd = rd_a[0];  assign b0.in_data = din_a[0];
    assign b1.in_v = in_v[1];  assign b1.op = op_a[1];  assign b1.rd = rd_a[1];  assign b1.in_data = din_a[1];
    assign b2.in_v = in_v[2];  assign b2.op = op_a[2];  assign b2.rd = rd_a[2];  assign b2.in_data = din_a[2];

    assign rdy_a[0] = b0.in_ready; assign ov_a[0] = b0.out_v; assign ord_a[0] = b0.out_rd;
    assign od_a[0]  = b0.out_data; assign oe_a[0] = b0.out_err;
    assign rdy_a[1] = b1.in_ready; assign ov_a[1] = b1.out_v; assign ord_a[1] = b1.out_rd;
    assign od_a[1]  = b1.out_data; assign oe_a[1] = b1.out_err;
    assign rdy_a[2] = b2.in_ready; assign ov_a[2] = b2.out_v; assign ord_a[2] = b2.out_rd;
    assign od_a[2]  = b2.out_data; assign oe_a[2] = b2.out_err;
    assign cnt_a[0] = 32'(c0); assign cnt_a[1] = 32'(c1); assign cnt_a[2] = 32'(c2);
    assign emp_a[0] = e0; assign emp_a[1] = e1; assign emp_a[2] = e2;
    assign ful_a[0] = f0; assign ful_a[1] = f1; assign ful_a[2] = f2;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov_a[k] === 1'b1) begin
                if (sbq.size() == 0) begin
                    check($sformatf("unexpected_rsp_dut%0d", k), ov_a[k], 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_dut", k, e.dut);
                    check($sformatf("rsp_data_dut%0d", k), od_a[k], e.data);
                    check($sformatf("rsp_err_dut%0d", k), oe_a[k], e.err);
                    check($sformatf("rsp_rd_dut%0d", k), ord_a[k], e.rd);
                    check($sformatf("rsp_lat_dut%0d", k), cyc + 1 - e.acc, e.lat);
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic issue(input int k, input logic [1:0] o, input logic [4:0] r, input logic [31:0] d,
                         input logic [31:0] xd, input logic xe, input int xl, input bit want = 1'b1);
        int n = 0;
        exp_t e;
        @(negedge clk);
        in_v[k] = 1'b1; op_a[k] = o; rd_a[k] = r; din_a[k] = d;
        while (!rdy_a[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_a[k]) begin
            check("accept_timeout", rdy_a[k], 1);
            in_v[k] = 1'b0;
            return;
        end
        if (want) begin
            e.dut = k; e.rd = r; e.data = xd; e.err = xe; e.lat = xl; e.acc = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        in_v[k] = 1'b0;
        if (want)
            wait_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int accepts;
        int mc;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; in_v[k] = 1'b0; op_a[k] = PEEK; rd_a[k] = '0; din_a[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_out_v%0d", k), ov_a[k], 0);
            check($sformatf("rst_out_err%0d", k), oe_a[k], 0);
            check($sformatf("rst_out_data%0d", k), od_a[k], 0);
            check($sformatf("rst_out_rd%0d", k), ord_a[k], 0);
            check($sformatf("rst_count%0d", k), cnt_a[k], 0);
            check($sformatf("rst_empty%0d", k), emp_a[k], 1);
            check($sformatf("rst_in_ready%0d", k), rdy_a[k], 0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("post_rst_ready%0d", k), rdy_a[k], 1);

        // DUT0 max-heap depth 4: fill, overflow, drain, underflow
        issue(0, PUSH, 5'd1, 32'd5, 32'd1, 1'b0, 2);
        issue(0, PUSH, 5'd2, 32'd9, 32'd2, 1'b0, 3);
        issue(0, PUSH, 5'd3, 32'd3, 32'd3, 1'b0, 2);
        issue(0, PUSH, 5'd4, 32'd7, 32'd4, 1'b0, 3);
        check("full_after_4", ful_a[0], 1);
        issue(0, PUSH, 5'd5, 32'd1, 32'd0, 1'b1, 1);
        check("count_after_full_push", cnt_a[0], 4);
        issue(0, POP, 5'd6, 32'd0, 32'd9, 1'b0, 3);
        issue(0, POP, 5'd7, 32'd0, 32'd7, 1'b0, 3);
        issue(0, POP, 5'd8, 32'd0, 32'd5, 1'b0, 2);
        issue(0, POP, 5'd9, 32'd0, 32'd3, 1'b0, 2);
        check("empty_after_4_pops", emp_a[0], 1);
        issue(0, POP, 5'd10, 32'd0, 32'd0, 1'b1, 1);
        issue(0, PEEK, 5'd11, 32'd0, 32'd0, 1'b1, 1);

        // DUT0 replace on {9,7,5}
        issue(0, PUSH, 5'd12, 32'd9, 32'd1, 1'b0, 2);
        issue(0, PUSH, 5'd13, 32'd7, 32'd2, 1'b0, 2);
        issue(0, PUSH, 5'd14, 32'h105, 32'd3, 1'b0, 2);
        issue(0, REPL, 5'd15, 32'd2, 32'd9, 1'b0, 3);
        check("count_after_replace", cnt_a[0], 3);
        issue(0, POP, 5'd16, 32'd0, 32'd7, 1'b0, 2);
        issue(0, POP, 5'd17, 32'd0, 32'd5, 1'b0, 2);
        issue(0, POP, 5'd18, 32'd0, 32'd2, 1'b0, 2);

        // DUT1 min-heap
        issue(1, PUSH, 5'd1, 32'd4, 32'd1, 1'b0, 2);
        issue(1, PUSH, 5'd2, 32'd1, 32'd2, 1'b0, 3);
        issue(1, PUSH, 5'd3, 32'd3, 32'd3, 1'b0, 2);
        issue(1, PEEK, 5'd17, 32'd0, 32'd1, 1'b0, 1);
        check("min_count_after_peek", cnt_a[1], 3);
        issue(1, REPL, 5'd20, 32'd5, 32'd1, 1'b0, 3);
        issue(1, PEEK, 5'd21, 32'd0, 32'd3, 1'b0, 1);

        // DUT2 max-heap depth 8: two-swap push, then reset during sift-down
        issue(2, PUSH, 5'd1, 32'd9, 32'd1, 1'b0, 2);
        issue(2, PUSH, 5'd2, 32'd7, 32'd2, 1'b0, 2);
        issue(2, PUSH, 5'd3, 32'd5, 32'd3, 1'b0, 2);
        issue(2, PUSH, 5'd4, 32'd3, 32'd4, 1'b0, 2);
        issue(2, PUSH, 5'd5, 32'd10, 32'd5, 1'b0, 4);
        issue(2, POP, 5'd6, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        rst[2] = 1'b1;
        #1;
        check("midop_rst_out_v", ov_a[2], 0);
        check("midop_rst_count", cnt_a[2], 0);
        @(negedge clk);
        rst[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("midop_no_rsp", sbq.size(), 0);
        issue(2, POP, 5'd7, 32'd0, 32'd0, 1'b1, 1);

        // DUT2 in_v held high: only ready cycles accept, one response each
        @(negedge clk);
        in_v[2] = 1'b1; op_a[2] = PUSH; rd_a[2] = 5'd3; din_a[2] = 32'd1;
        accepts = 0;
        mc = 0;
        for (int i = 0; i < 7; i++) begin
            if (rdy_a[2]) begin
                mc++;
                accepts++;
                e.dut = 2; e.rd = 5'd3; e.data = mc; e.err = 1'b0; e.lat = 2; e.acc = cyc + 1;
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        in_v[2] = 1'b0;
        wait_drain();
        check("held_in_v_accepts", accepts, 4);
        check("held_in_v_count", cnt_a[2], 4);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
